// File: rtl/rf_wr_arbiter_if.sv
// Bundle of WB, MDU, issue, hazard-lookup and register-file write signals
// around the shared RF write-port arbiter.
interface rf_wr_arbiter_if;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        iss_busy;
  logic        pipe_stall;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  modport master (
    output wb_wr, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           iss_valid, iss_addr, rs_addr, rt_addr,
    input  mdu_ready, rs_busy, rt_busy, iss_busy, pipe_stall,
           rf_wr, rf_addr, rf_wd
  );

  modport slave (
    input  wb_wr, wb_addr, wb_data, mdu_valid, mdu_addr, mdu_data,
           iss_valid, iss_addr, rs_addr, rt_addr,
    output mdu_ready, rs_busy, rt_busy, iss_busy, pipe_stall,
           rf_wr, rf_addr, rf_wd
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Shares the RF write port between the WB stage (priority) and a small FIFO of
// MDU results, with a pending-destination scoreboard and a starvation stall.
module rf_wr_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int AGE_W      = 3
) (
  input  logic           clk,
  input  logic           rst,
  rf_wr_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             stall_q, stall_d;
  logic [31:0]      pending_q, pending_d;

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic        empty, full, wb_use, drain, accept, push;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign wb_use    = bus.wb_wr && (bus.wb_addr != 5'd0);
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign drain     = !rst && !wb_use && !empty;
  assign accept    = bus.mdu_valid && bus.mdu_ready;
  // Results bound for r0 complete the handshake but are never stored.
  assign push      = accept && (bus.mdu_addr != 5'd0);

  assign bus.mdu_ready  = !rst && !full;
  assign bus.pipe_stall = stall_q;
  assign bus.rs_busy    = pending_q[bus.rs_addr];
  assign bus.rt_busy    = pending_q[bus.rt_addr];
  assign bus.iss_busy   = pending_q[bus.iss_addr];

  always_comb begin
    bus.rf_wr   = 1'b0;
    bus.rf_addr = 5'd0;
    bus.rf_wd   = 32'd0;
    if (!rst) begin
      if (wb_use) begin
        bus.rf_wr   = 1'b1;
        bus.rf_addr = bus.wb_addr;
        bus.rf_wd   = bus.wb_data;
      end else if (!empty) begin
        bus.rf_wr   = 1'b1;
        bus.rf_addr = head_addr;
        bus.rf_wd   = head_data;
      end
    end
  end

  always_comb begin
    rd_ptr_d = drain ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(drain);
  end

  always_comb begin
    age_d   = age_q;
    stall_d = stall_q;
    if (empty || drain) begin
      age_d = '0;
    end else if (age_q != AGE_W'(STARVE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
    if (drain) begin
      stall_d = 1'b0;
    end else if (age_d == AGE_W'(STARVE_MAX)) begin
      stall_d = 1'b1;
    end
  end

  // A set in the same cycle as the drain clear wins, so a reissued address stays busy.
  assign pending_d[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_pend
    assign pending_d[gi] = (bus.iss_valid && (bus.iss_addr == 5'(gi)))
                        || (pending_q[gi] && !(drain && (head_addr == 5'(gi))));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.mdu_addr;
      data_mem[wr_ptr_q] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      stall_q   <= 1'b0;
      pending_q <= 32'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      stall_q   <= stall_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed vector table, hand-written
// reset/latency sequences and randomized traffic against a queue-based model.
module tb_rf_wr_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  rf_wr_arbiter_if bus();

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .AGE_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  rs;
    logic        e_rdy;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_busy;
    logic        e_isb;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t tbl[16];
  ent_t mq[$];
  bit   mpend[32];
  int   m_age;
  bit   m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic wb_wr, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic iv, input logic [4:0] ia);
    bus.wb_wr     = wb_wr;
    bus.wb_addr   = wb_addr;
    bus.wb_data   = wb_data;
    bus.mdu_valid = mv;
    bus.mdu_addr  = ma;
    bus.mdu_data  = md;
    bus.iss_valid = iv;
    bus.iss_addr  = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    set_in(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 32'd1, 1'b0, 5'd0);

    // Outputs held quiet during reset even with WB asking for the port.
    @(negedge clk);
    chk("rst_rf_wr", bus.rf_wr, 1'b0);
    chk("rst_ready", bus.mdu_ready, 1'b0);
    chk("rst_stall", bus.pipe_stall, 1'b0);
    do_reset();
    @(negedge clk);
    chk("post_rst_ready", bus.mdu_ready, 1'b1);
    chk("post_rst_rf_wr", bus.rf_wr, 1'b0);
    tick();

    // wb_wr wb_addr wb_data  mv ma md  iv ia  rs | rdy wr addr wd busy isb stall
    tbl[0]  = '{1'b1, 5'd1, 32'h11,   1'b0, 5'd0,  32'h0,  1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd8,  32'h1,  1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3, 32'h33,   1'b1, 5'd9,  32'h2,  1'b0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd4, 32'h44,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 5'd5, 32'h55,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 5'd6, 32'h66,   1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 5'd7, 32'h77,   1'b1, 5'd10, 32'h3,  1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd8, 1'b0, 1'b1, 5'd8, 32'h1,  1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd9, 32'h2,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd3,  32'h55, 1'b0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0,  32'h99, 1'b0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd3, 32'h55, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7,  32'h70, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'h70, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0,  1'b0, 5'd7, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].wb_wr, tbl[i].wb_addr, tbl[i].wb_data, tbl[i].mv, tbl[i].ma, tbl[i].md,
             tbl[i].iv, tbl[i].ia);
      bus.rs_addr = tbl[i].rs;
      bus.rt_addr = tbl[i].rs;
      @(negedge clk);
      $display("[TB] vec %0d rf_wr=%0b addr=%0d wd=%0h ready=%0b stall=%0b",
               i, bus.rf_wr, bus.rf_addr, bus.rf_wd, bus.mdu_ready, bus.pipe_stall);
      chk($sformatf("vec%0d_ready", i), bus.mdu_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_rf_wr", i), bus.rf_wr, tbl[i].e_wr);
      chk($sformatf("vec%0d_rf_addr", i), bus.rf_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_rf_wd", i), bus.rf_wd, tbl[i].e_wd);
      chk($sformatf("vec%0d_rs_busy", i), bus.rs_busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_rt_busy", i), bus.rt_busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_iss_busy", i), bus.iss_busy, tbl[i].e_isb);
      chk($sformatf("vec%0d_stall", i), bus.pipe_stall, tbl[i].e_stall);
      tick();
    end

    // Reset mid-operation with two results buffered and r8/r9 pending.
    set_in(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8);
    tick();
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'hA8, 1'b1, 5'd9);
    tick();
    set_in(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'hA9, 1'b0, 5'd0);
    tick();
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    bus.rs_addr = 5'd8;
    bus.rt_addr = 5'd9;
    #1;
    $display("[TB] pre-reset rs_busy=%0b rt_busy=%0b ready=%0b", bus.rs_busy, bus.rt_busy, bus.mdu_ready);
    chk("midrst_pre_busy8", bus.rs_busy, 1'b1);
    chk("midrst_pre_busy9", bus.rt_busy, 1'b1);
    chk("midrst_pre_ready", bus.mdu_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_rf_wr", bus.rf_wr, 1'b0);
    chk("midrst_ready", bus.mdu_ready, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] post-reset rf_wr=%0b ready=%0b stall=%0b", bus.rf_wr, bus.mdu_ready, bus.pipe_stall);
    chk("midrst_post_rf_wr", bus.rf_wr, 1'b0);
    chk("midrst_post_ready", bus.mdu_ready, 1'b1);
    chk("midrst_post_stall", bus.pipe_stall, 1'b0);
    chk("midrst_post_busy8", bus.rs_busy, 1'b0);
    chk("midrst_post_busy9", bus.rt_busy, 1'b0);
    tick();

    // Issue r5 at cycle 0, result at cycle 3, written in cycle 4.
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd0;
    for (int c = 0; c < 6; c++) begin
      set_in(1'b0, 5'd0, 32'd0, (c == 3), 5'd5, 32'hDEADBEEF, (c == 0), 5'd5);
      @(negedge clk);
      $display("[TB] r5 cycle %0d rs_busy=%0b rf_wr=%0b addr=%0d wd=%0h",
               c, bus.rs_busy, bus.rf_wr, bus.rf_addr, bus.rf_wd);
      chk($sformatf("r5_c%0d_busy", c), bus.rs_busy, (c >= 1 && c <= 4));
      chk($sformatf("r5_c%0d_rf_wr", c), bus.rf_wr, (c == 4));
      if (c == 4) begin
        chk("r5_rf_addr", bus.rf_addr, 5'd5);
        chk("r5_rf_wd", bus.rf_wd, 32'hDEADBEEF);
      end
      tick();
    end

    // Randomized traffic against a queue/array reference model.
    do_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    m_age   = 0;
    m_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int          wb_pct;
      logic        use_wb, e_rdy, e_wr, drain;
      logic [4:0]  e_addr, ia;
      logic [31:0] e_wd;
      ent_t        h;
      wb_pct = ((c / 50) % 2 == 1) ? 90 : 30;
      ia = 5'($urandom_range(0, 31));
      set_in($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
             ($urandom_range(0, 2) == 0) && !mpend[ia], ia);
      bus.rs_addr = 5'($urandom_range(0, 31));
      bus.rt_addr = 5'($urandom_range(0, 31));
      @(negedge clk);
      use_wb = bus.wb_wr && (bus.wb_addr != 5'd0);
      e_rdy  = (mq.size() < DEPTH);
      e_wr   = use_wb || (mq.size() > 0);
      e_addr = use_wb ? bus.wb_addr : (mq.size() > 0 ? mq[0].a : 5'd0);
      e_wd   = use_wb ? bus.wb_data : (mq.size() > 0 ? mq[0].d : 32'd0);
      $display("[TB] rnd %0d rf_wr=%0b addr=%0d wd=%0h ready=%0b stall=%0b",
               c, bus.rf_wr, bus.rf_addr, bus.rf_wd, bus.mdu_ready, bus.pipe_stall);
      chk("rnd_ready", bus.mdu_ready, e_rdy);
      chk("rnd_rf_wr", bus.rf_wr, e_wr);
      chk("rnd_rf_addr", bus.rf_addr, e_addr);
      chk("rnd_rf_wd", bus.rf_wd, e_wd);
      chk("rnd_rs_busy", bus.rs_busy, mpend[bus.rs_addr]);
      chk("rnd_rt_busy", bus.rt_busy, mpend[bus.rt_addr]);
      chk("rnd_iss_busy", bus.iss_busy, mpend[bus.iss_addr]);
      chk("rnd_stall", bus.pipe_stall, m_stall);
      drain = !use_wb && (mq.size() > 0);
      if (drain) begin
        h = mq.pop_front();
        mpend[h.a] = 1'b0;
        m_age   = 0;
        m_stall = 1'b0;
      end else if (mq.size() == 0) begin
        m_age = 0;
      end else begin
        if (m_age < STARVE_MAX) m_age++;
        if (m_age == STARVE_MAX) m_stall = 1'b1;
      end
      if (bus.mdu_valid && e_rdy && bus.mdu_addr != 5'd0) begin
        h.a = bus.mdu_addr;
        h.d = bus.mdu_data;
        mq.push_back(h);
      end
      if (bus.iss_valid && bus.iss_addr != 5'd0) mpend[bus.iss_addr] = 1'b1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port (rf_wr/rf_addr/rf_wd → RFWr/A3/WD) between the pipeline WB stage and the multi-cycle MDU/late-load unit.
- Buffers MDU results in a small FIFO and tracks outstanding MDU destinations in a 32-bit pending scoreboard, which the hazard unit queries for rs/rt.
- Sits between the WB stage, the MDU and the RF. It also raises a stall request when an MDU result has been starved of the port too long.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2).
- STARVE_MAX, 4, cycles the FIFO head may wait before pipe_stall is requested (≥1).
- AGE_W, 3, width of the head-age counter; must hold STARVE_MAX.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_wr  in  1  pipeline WB write enable
- wb_addr  in  5  pipeline WB destination register
- wb_data  in  32  pipeline WB write data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  arbiter can accept an MDU result
- mdu_addr  in  5  MDU destination register
- mdu_data  in  32  MDU result data
- iss_valid  in  1  MDU operation issued this cycle; marks iss_addr pending
- iss_addr  in  5  destination of issued MDU operation
- rs_addr  in  5  hazard-unit lookup A
- rt_addr  in  5  hazard-unit lookup B
- rs_busy  out  1  pending[rs_addr], combinational
- rt_busy  out  1  pending[rt_addr], combinational
- iss_busy  out  1  pending[iss_addr], combinational
- pipe_stall  out  1  registered request for WB bubbles
- rf_wr  out  1  to RF RFWr
- rf_addr  out  5  to RF A3
- rf_wd  out  32  to RF WD

Behaviour:
- Reset: the following are cleared asynchronously.
  - FIFO empty, pending = 0, age = 0, pipe_stall = 0.
  - rf_wr forced 0 while rst is high; mdu_ready = 0 while rst is high.
  - Reset mid-operation discards all buffered results and pending bits.
- Port select (combinational):
  - wb_use = wb_wr && wb_addr != 0.
  - If wb_use, drive rf_wr = 1 with wb_addr/wb_data. WB always wins.
  - Else if the FIFO is non-empty, drive rf_wr = 1 with the head's addr/data, and the head pops at the edge.
  - Else rf_wr = 0, and rf_addr/rf_wd = 0.
- Writes to r0 never use the port. wb_wr with wb_addr = 0 is ignored, and the FIFO may drain in that cycle.
- MDU handshake:
  - mdu_ready = !full, from registered count.
  - Transfer occurs on mdu_valid && mdu_ready at the edge.
  - An accepted result with mdu_addr = 0 is consumed and dropped, not stored.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Minimum latency: accepted at edge N, rf_wr asserted in cycle N+1, written to RF at edge N+1.
- FIFO: in-order, circular read/write pointers mod DEPTH, count 0..DEPTH. No bypass from the mdu_* inputs to the rf_* outputs.
- Scoreboard pending[31:0]:
  - Set pending[iss_addr] on iss_valid when iss_addr != 0; pending[0] is always 0.
  - Clear pending[head addr] at the edge the head drains.
  - If a set and a clear hit the same address in the same cycle, the bit stays 1.
  - The issuer must not issue to an address while iss_busy = 1; behaviour is undefined if it does.
- Starvation:
  - age counts cycles the FIFO is non-empty and the head does not drain. It resets to 0 on drain or when the FIFO is empty.
  - pipe_stall is set at the edge where age reaches STARVE_MAX.
  - pipe_stall is cleared at the edge the head drains.
  - The pipeline responds to pipe_stall by presenting wb_wr = 0.
- Simultaneous MDU arrival with wb_use: the result is accepted into the FIFO if not full; nothing is lost.

Test Plan:
- Reset mid-operation: 2 entries buffered, pending = 0x0000_0300, then rst pulse → FIFO empty, pending = 0, rf_wr = 0, mdu_ready = 1 after release, pipe_stall = 0.
- Idle WB, iss r5 at cycle 0, mdu result r5 = 0xDEADBEEF at cycle 3 → rf_wr = 1 with addr 5 / 0xDEADBEEF in cycle 4; rs_busy for r5 is 1 from cycles 1–4 and 0 from cycle 5.
- WB writes every cycle with nonzero addresses, two MDU results r8 = 1 and r9 = 2 → mdu_ready = 0 after the 2nd push; pipe_stall = 1 after 4 starved cycles. Once wb_wr drops, r8 is written, then r9, in order; pipe_stall clears at r8's drain.
- wb_wr = 1 with wb_addr = 0 and FIFO head r3 = 0x55 → rf_wr writes r3 = 0x55 in the same cycle; no write to r0.
- MDU result with mdu_addr = 0 → accepted (mdu_ready handshake completes), count unchanged, rf_wr never targets r0.
- iss_valid to r7 in the same cycle r7's old result drains → pending[7] remains 1; iss_busy for r7 reads 1 next cycle.
